div_hilo_sequencer: RTL and testbench
=====================================

Name: div_hilo_sequencer

Overview:
- Sits between the control unit and the DIV block.
- Accepts a divide request and latches the operands. Pulses CtrlDiv to the divider, checks DivZero, waits for DivStop, then commits HI/LO into the architectural HI/LO registers.
- Gives the control unit a busy/stall, a done pulse and a divide-by-zero exception flag.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- TIMEOUT, 48, max cycles spent in WAIT before a timeout error (only used with DIV_TIMEOUT_EN).
- CW, 6, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  divide request from control unit; sampled only in IDLE.
- op_a  in  32  dividend (signed).
- op_b  in  32  divisor (signed).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO write data.
- DivStop  in  1  divider completion level.
- DivZero  in  1  divider zero-divisor flag; valid in the cycle after CtrlDiv is sampled.
- div_hi  in  32  divider HI (remainder).
- div_lo  in  32  divider LO (quotient).
- CtrlDiv  out  1  registered one-cycle start pulse to divider.
- div_a  out  32  latched dividend to divider.
- div_b  out  32  latched divisor to divider.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when HI/LO are committed.
- div_zero_exc  out  1  one-cycle pulse on divide by zero.
- timeout_err  out  1  one-cycle pulse on watchdog expiry (DIV_TIMEOUT_EN only, else tied 0).
- hi  out  32  architectural HI (MFHI source).
- lo  out  32  architectural LO (MFLO source).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - CtrlDiv, busy, done, div_zero_exc and timeout_err all 0.
  - div_a, div_b, hi and lo all 0.
  - Wait counter 0.
  - Reset mid-operation abandons the division; HI/LO are not committed.
- States: IDLE, ISSUE, CHECK, WAIT, COMMIT.
- IDLE:
  - start=1 latches op_a→div_a and op_b→div_b, then goes to ISSUE.
  - hi_we / lo_we write wdata to hi / lo.
  - start together with a write in the same cycle: the write takes effect and start is also accepted.
- ISSUE: CtrlDiv=1 for exactly this cycle; → CHECK.
- CHECK:
  - DivZero=1: pulse div_zero_exc next cycle, hi/lo unchanged, → IDLE.
  - Otherwise: clear the wait counter, → WAIT.
- WAIT:
  - DivStop=1: register div_hi→hi and div_lo→lo, → COMMIT.
  - Otherwise: increment the wait counter.
  - DivStop is only trusted from WAIT onward; the stale level from the previous operation is cleared by the divider when it samples CtrlDiv.
- COMMIT: done=1 for this one cycle; → IDLE.
- busy is a registered output, high from the cycle after start is accepted until the cycle the FSM returns to IDLE.
- Latency: start accepted at edge 0; CtrlDiv high in cycle 1; hi/lo are updated at the edge on which WAIT samples DivStop=1, and done is high in the following cycle.
- No arithmetic is done here; hi/lo take the divider's two's-complement results verbatim.
- start, hi_we and lo_we are ignored while busy=1; they are not queued.
- Outputs div_a / div_b are held stable from ISSUE through COMMIT.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined:
  - In WAIT, when the counter reaches TIMEOUT with DivStop still 0, pulse timeout_err for one cycle.
  - hi/lo are left unchanged and the FSM returns to IDLE.
- Undefined:
  - No counter logic and timeout_err is tied 0.
  - WAIT persists until DivStop or reset.

Test Plan:
- op_a=100, op_b=7, start 1 cycle, divider model → hi=2, lo=14; one done pulse; CtrlDiv high exactly 1 cycle; busy drops with return to IDLE.
- op_a=-100 (0xFFFFFF9C), op_b=7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE; done pulses once.
- op_b=0, DivZero=1 in CHECK → div_zero_exc single pulse; no done pulse; hi/lo keep their prior values (preload via MTHI=0x11, MTLO=0x22).
- DivStop tied 0, DIV_TIMEOUT_EN defined, TIMEOUT=48 → timeout_err pulses once after 48 WAIT cycles; FSM returns to IDLE; hi/lo unchanged. Without the macro → busy stays 1 indefinitely.
- reset driven low in WAIT → all outputs, hi and lo are 0 immediately (async); after release, a new start works normally.
- hi_we=1, wdata=0xDEAD while busy → ignored; after done, hi is the divider result. hi_we with start in IDLE → hi=0xDEAD, later overwritten by the divide result.

Source files
------------

// File: rtl/div_hilo_sequencer.sv
// Sequences one signed divide through the external DIV block and owns the
// architectural HI/LO registers. Optional WAIT watchdog: `define DIV_TIMEOUT_EN.
module div_hilo_sequencer #(
  parameter int unsigned TIMEOUT = 48,
  parameter int unsigned CW      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        DivStop,
  input  logic        DivZero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        CtrlDiv,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_err,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_CHECK  = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  // The wait counter must be able to hold TIMEOUT.
  if ((2 ** CW) <= TIMEOUT) begin : g_cw_check
    $error("div_hilo_sequencer: CW too narrow for TIMEOUT");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_commit;
  logic        w_zero;

  logic        r_ctrl_div;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero_exc;
  logic [31:0] r_div_a;
  logic [31:0] r_div_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

`ifdef DIV_TIMEOUT_EN
  logic          r_timeout_err;
  logic          w_timeout;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_wait_cnt + CW'(1);

  // Counts WAIT cycles spent without DivStop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_CHECK) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_WAIT) && !DivStop) begin
      r_wait_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_zero      = 1'b0;
`ifdef DIV_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (DivZero) begin
          w_zero      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DivStop) begin
          w_commit    = 1'b1;
          w_state_nxt = S_COMMIT;
        end
`ifdef DIV_TIMEOUT_EN
        else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered copies of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl_div     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_div_zero_exc <= 1'b0;
    end else begin
      r_ctrl_div     <= (w_state_nxt == S_ISSUE);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (w_state_nxt == S_COMMIT);
      r_div_zero_exc <= w_zero;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_a <= '0;
      r_div_b <= '0;
    end else if (w_accept) begin
      r_div_a <= op_a;
      r_div_b <= op_b;
    end
  end

  // MTHI/MTLO only land in IDLE; a commit can never coincide with IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= div_hi;
      r_lo <= div_lo;
    end else if (r_state == S_IDLE) begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign CtrlDiv      = r_ctrl_div;
  assign busy         = r_busy;
  assign done         = r_done;
  assign div_zero_exc = r_div_zero_exc;
  assign div_a        = r_div_a;
  assign div_b        = r_div_b;
  assign hi           = r_hi;
  assign lo           = r_lo;

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Randomized self-checking bench for div_hilo_sequencer with a behavioural
// divider and a magnitude-based HI/LO reference model.
`timescale 1ns/1ps
module tb_div_hilo_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        DivStop = 1'b0;
  logic        DivZero = 1'b0;
  logic [31:0] div_hi  = '0;
  logic [31:0] div_lo  = '0;
  logic        CtrlDiv;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic        timeout_err;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        stall_stop = 1'b0;

  div_hilo_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .DivStop(DivStop), .DivZero(DivZero), .div_hi(div_hi), .div_lo(div_lo),
    .CtrlDiv(CtrlDiv), .div_a(div_a), .div_b(div_b), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout_err(timeout_err), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Pulse counters sampled mid-cycle; only ever grow.
  int n_ctrl = 0, n_done = 0, n_zero = 0, n_tmo = 0;
  always @(negedge clk) begin
    if (CtrlDiv === 1'b1)      n_ctrl++;
    if (done === 1'b1)         n_done++;
    if (div_zero_exc === 1'b1) n_zero++;
    if (timeout_err === 1'b1)  n_tmo++;
  end

  // Divider: samples CtrlDiv, flags zero next cycle, raises DivStop after a random delay.
  logic        dv_pend = 1'b0;
  int unsigned dv_lat  = 0;
  logic [31:0] dv_q    = '0;
  logic [31:0] dv_r    = '0;
  always @(posedge clk) begin
    if (CtrlDiv === 1'b1) begin
      DivStop <= 1'b0;
      DivZero <= (div_b == 32'd0);
      dv_pend <= (div_b != 32'd0) && !stall_stop;
      dv_lat  <= $urandom_range(0, 5);
      if (div_b != 32'd0) begin
        dv_q <= $signed(div_a) / $signed(div_b);
        dv_r <= $signed(div_a) % $signed(div_b);
      end
    end else if (dv_pend) begin
      if (dv_lat == 0) begin
        DivStop <= 1'b1;
        div_hi  <= dv_r;
        div_lo  <= dv_q;
        dv_pend <= 1'b0;
      end else begin
        dv_lat <= dv_lat - 1;
      end
    end
  end

  // Reference: truncating signed divide via unsigned magnitudes; returns {rem, quo}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, mq, q, r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    mq = ma / mb;
    q  = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
    r  = a - q * b;
    return {r, q};
  endfunction

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    @(posedge clk); #1;
    hi_we = h; lo_we = l; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
  endtask

  // mode 0: plain, 1: MTHI/MTLO while busy, 2: MTHI in the start cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input logic stall, output int cyc);
    int c_ctrl, c_done, c_zero, c_tmo;
    logic ended, stable;
    logic [63:0] rq;
    c_ctrl = n_ctrl; c_done = n_done; c_zero = n_zero; c_tmo = n_tmo;
    stall_stop = stall;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b;
    if (mode == 2) begin hi_we = 1'b1; wdata = 32'h0000_DEAD; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    if (mode == 2) begin
      exp_hi = 32'h0000_DEAD;
      check("wr_with_start_hi", hi, exp_hi);
    end
    check("busy_after_start", 32'(busy), 32'd1);
    check("div_a_latched", div_a, a);
    check("div_b_latched", div_b, b);
    op_a = $urandom; op_b = $urandom;
    if (mode == 1) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD; end
    ended = 1'b0; stable = 1'b1; cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ended = 1'b1; cyc = i; break; end
      if (div_a !== a || div_b !== b) stable = 1'b0;
    end
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk); #1;
    check("op_ended", 32'(ended), 32'd1);
    check("operands_stable", 32'(stable), 32'd1);
    if (b != 32'd0 && !stall) begin
      rq = ref_div(a, b);
      exp_hi = rq[63:32];
      exp_lo = rq[31:0];
    end
    check("ctrl_pulses", 32'(n_ctrl - c_ctrl), 32'd1);
    check("done_pulses", 32'(n_done - c_done), (b != 32'd0 && !stall) ? 32'd1 : 32'd0);
    check("zero_pulses", 32'(n_zero - c_zero), (b == 32'd0) ? 32'd1 : 32'd0);
    check("tmo_pulses",  32'(n_tmo - c_tmo),  (b != 32'd0 && stall) ? 32'd1 : 32'd0);
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
  endtask

  initial begin
    int cyc, c0;
    logic [31:0] a, b;
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'(CtrlDiv), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_zero", 32'(div_zero_exc), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    reset = 1'b1;

    run_op(32'd100, 32'd7, 0, 1'b0, cyc);
    check("tp_pos_hi", hi, 32'd2);
    check("tp_pos_lo", lo, 32'd14);

    run_op(32'hFFFF_FF9C, 32'd7, 0, 1'b0, cyc);
    check("tp_neg_hi", hi, 32'hFFFF_FFFE);
    check("tp_neg_lo", lo, 32'hFFFF_FFF2);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    run_op(32'd5, 32'd0, 0, 1'b0, cyc);
    check("tp_zero_hi", hi, 32'h11);
    check("tp_zero_lo", lo, 32'h22);

    run_op(32'd1000, 32'd3, 1, 1'b0, cyc);
    check("tp_busywr_hi", hi, 32'd1);
    check("tp_busywr_lo", lo, 32'd333);

    run_op(32'd77, 32'd5, 2, 1'b0, cyc);
    check("tp_startwr_hi", hi, 32'd2);
    check("tp_startwr_lo", lo, 32'd15);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 20);
        4:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'd0;
      if ($urandom_range(0, 3) == 0) mt(1'($urandom), 1'($urandom), $urandom);
      run_op(a, b, int'($urandom_range(0, 2)), 1'b0, cyc);
    end

    // Reset asserted while the sequencer sits in WAIT.
    mt(1'b1, 1'b1, 32'h5A5A_A5A5);
    stall_stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'd123; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ctrl", 32'(CtrlDiv), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_div_a", div_a, 32'd0);
    check("arst_div_b", div_b, 32'd0);
    @(posedge clk); #1;
    check("arst_hold_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    run_op(32'd50, 32'hFFFF_FFFA, 0, 1'b0, cyc);
    check("post_rst_hi", hi, 32'd2);
    check("post_rst_lo", lo, 32'hFFFF_FFF8);

`ifdef DIV_TIMEOUT_EN
    mt(1'b1, 1'b1, 32'h1234_5678);
    run_op(32'd10, 32'd3, 0, 1'b1, cyc);
    check("tmo_latency", 32'(cyc), 32'd50);
    stall_stop = 1'b0;
    run_op(32'd10, 32'd3, 0, 1'b0, cyc);
`else
    c0 = n_tmo;
    stall_stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'd10; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("no_tmo_busy", 32'(busy), 32'd1);
    check("no_tmo_pulses", 32'(n_tmo - c0), 32'd0);
    reset = 1'b0;
    #2 reset = 1'b1;
    stall_stop = 1'b0;
    exp_hi = '0; exp_lo = '0;
    run_op(32'd10, 32'd3, 0, 1'b0, cyc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
